// File: rtl/exec_writeback_pkg.sv
// Shared definitions for the execute/writeback stage: ALU opcodes, flag bundle
// and the hardwired-zero register index.
package definitions;

  typedef enum logic [2:0] {
    kADD  = 3'd0,
    kSUB  = 3'd1,
    kSHL  = 3'd2,
    kSHR  = 3'd3,
    kXOR  = 3'd4,
    kAND  = 3'd5,
    kOR   = 3'd6,
    kPASS = 3'd7
  } op_mne;

  typedef struct packed {
    logic c;
    logic s;
    logic z;
  } flags_t;

  localparam int unsigned kZERO_REG = 0;

  // Only the arithmetic ops own the carry and only the shifts own the shift-out flag.
  function automatic logic op_writes_c(input op_mne op);
    return (op == kADD) || (op == kSUB);
  endfunction

  function automatic logic op_writes_s(input op_mne op);
    return (op == kSHL) || (op == kSHR);
  endfunction

endpackage

// File: rtl/exec_writeback_flag_reg.sv
// Architectural C/S/Z flag register with op-to-flag selection and the
// start-of-sequence clear merged underneath the op's own flag write.
module flag_reg
  import definitions::*;
(
  input  logic   CLK,
  input  logic   RESET,
  input  logic   upd_i,
  input  op_mne  op_i,
  input  logic   clr_i,
  input  flags_t alu_flags_i,
  output flags_t flags_o
);

  flags_t flags_q;
  flags_t flags_d;

  // The clear is applied first so a same-cycle flag-updating op overrides it.
  always_comb begin
    flags_d = flags_q;
    if (clr_i) begin
      flags_d.c = 1'b0;
      flags_d.s = 1'b0;
    end
    if (upd_i) begin
      if (op_writes_c(op_i)) flags_d.c = alu_flags_i.c;
      if (op_writes_s(op_i)) flags_d.s = alu_flags_i.s;
      flags_d.z = alu_flags_i.z;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) flags_q <= '0;
    else       flags_q <= flags_d;
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/exec_writeback.sv
// Execute/writeback stage: registers the ALU result for the register-file
// write port, owns the C/S/Z flags and forwards WB data to the operand muxes.
module exec_writeback
  import definitions::*;
#(
  parameter int DW  = 8,
  parameter int RAW = 3
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           EX_VALID,
  input  op_mne          EX_OP,
  input  logic           EX_WEN,
  input  logic [RAW-1:0] EX_DEST,
  input  logic           EX_FLAG_EN,
  input  logic           CLR_FLAGS,
  input  logic [DW-1:0]  ALU_OUT,
  input  logic           ALU_C_OUT,
  input  logic           ALU_S_OUT,
  input  logic           ALU_ZERO,
  input  logic           STALL,
  input  logic           FLUSH,
  input  logic [RAW-1:0] SRC_A_ADDR,
  input  logic [RAW-1:0] SRC_B_ADDR,
  output logic           C_FLAG,
  output logic           S_FLAG,
  output logic           Z_FLAG,
  output logic           WB_VALID,
  output logic           WB_WEN,
  output logic [RAW-1:0] WB_ADDR,
  output logic [DW-1:0]  WB_DATA,
  output logic           FWD_A_HIT,
  output logic           FWD_B_HIT
);

  localparam logic [RAW-1:0] ZeroAddr = RAW'(kZERO_REG);

  logic           advance;
  logic           accept;
  flags_t         alu_flags;
  flags_t         flags;

  logic           valid_q, valid_d;
  logic           wen_q,   wen_d;
  logic [RAW-1:0] addr_q,  addr_d;
  logic [DW-1:0]  data_q,  data_d;
  logic           fwd_live;

  assign advance   = ~STALL & ~FLUSH;
  assign accept    = EX_VALID & advance;
  assign alu_flags = {ALU_C_OUT, ALU_S_OUT, ALU_ZERO};

  flag_reg u_flag_reg (
    .CLK         (CLK),
    .RESET       (RESET),
    .upd_i       (accept & EX_FLAG_EN),
    .op_i        (EX_OP),
    .clr_i       (CLR_FLAGS & advance),
    .alu_flags_i (alu_flags),
    .flags_o     (flags)
  );

  // FLUSH kills the incoming slot even under STALL; a plain STALL holds everything.
  always_comb begin
    valid_d = valid_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (FLUSH) begin
      valid_d = 1'b0;
      wen_d   = 1'b0;
    end else if (!STALL) begin
      valid_d = EX_VALID;
      wen_d   = EX_VALID & EX_WEN;
      if (EX_VALID) begin
        addr_d = EX_DEST;
        data_d = ALU_OUT;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // wen_q is only ever set together with valid_q, so it already equals WB_VALID & wen.
  assign WB_VALID = valid_q;
  assign WB_WEN   = wen_q;
  assign WB_ADDR  = addr_q;
  assign WB_DATA  = data_q;

  assign C_FLAG = flags.c;
  assign S_FLAG = flags.s;
  assign Z_FLAG = flags.z;

  assign fwd_live  = wen_q & (addr_q != ZeroAddr);
  assign FWD_A_HIT = fwd_live & (SRC_A_ADDR == addr_q);
  assign FWD_B_HIT = fwd_live & (SRC_B_ADDR == addr_q);

endmodule

// File: tb/tb_exec_writeback.sv
// Directed scoreboard bench for exec_writeback: stimulus pushes hand-computed
// WB expectations, a negedge monitor pops one whenever WB_VALID is high.
module tb_exec_writeback;
  import definitions::*;

  localparam int DW  = 8;
  localparam int RAW = 3;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           EX_VALID;
  op_mne          EX_OP;
  logic           EX_WEN;
  logic [RAW-1:0] EX_DEST;
  logic           EX_FLAG_EN;
  logic           CLR_FLAGS;
  logic [DW-1:0]  ALU_OUT;
  logic           ALU_C_OUT;
  logic           ALU_S_OUT;
  logic           ALU_ZERO;
  logic           STALL;
  logic           FLUSH;
  logic [RAW-1:0] SRC_A_ADDR;
  logic [RAW-1:0] SRC_B_ADDR;
  logic           C_FLAG;
  logic           S_FLAG;
  logic           Z_FLAG;
  logic           WB_VALID;
  logic           WB_WEN;
  logic [RAW-1:0] WB_ADDR;
  logic [DW-1:0]  WB_DATA;
  logic           FWD_A_HIT;
  logic           FWD_B_HIT;

  exec_writeback #(.DW(DW), .RAW(RAW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .EX_VALID   (EX_VALID),
    .EX_OP      (EX_OP),
    .EX_WEN     (EX_WEN),
    .EX_DEST    (EX_DEST),
    .EX_FLAG_EN (EX_FLAG_EN),
    .CLR_FLAGS  (CLR_FLAGS),
    .ALU_OUT    (ALU_OUT),
    .ALU_C_OUT  (ALU_C_OUT),
    .ALU_S_OUT  (ALU_S_OUT),
    .ALU_ZERO   (ALU_ZERO),
    .STALL      (STALL),
    .FLUSH      (FLUSH),
    .SRC_A_ADDR (SRC_A_ADDR),
    .SRC_B_ADDR (SRC_B_ADDR),
    .C_FLAG     (C_FLAG),
    .S_FLAG     (S_FLAG),
    .Z_FLAG     (Z_FLAG),
    .WB_VALID   (WB_VALID),
    .WB_WEN     (WB_WEN),
    .WB_ADDR    (WB_ADDR),
    .WB_DATA    (WB_DATA),
    .FWD_A_HIT  (FWD_A_HIT),
    .FWD_B_HIT  (FWD_B_HIT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic           reset;
    logic           valid;
    op_mne          op;
    logic           wen;
    logic [RAW-1:0] dest;
    logic           flagEn;
    logic           clr;
    logic [DW-1:0]  out;
    logic           c;
    logic           s;
    logic           z;
    logic           stall;
    logic           flush;
  } stim_t;

  typedef struct {
    logic           valid;
    logic           wen;
    logic [RAW-1:0] addr;
    logic [DW-1:0]  data;
    logic           c;
    logic           s;
    logic           z;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t expQ[$];

  function automatic stim_t mkS(input logic reset, valid, input op_mne op,
                                input logic wen, input logic [RAW-1:0] dest,
                                input logic flagEn, clr, input logic [DW-1:0] out,
                                input logic c, s, z, stall, flush);
    stim_t r;
    r.reset = reset; r.valid = valid; r.op = op; r.wen = wen; r.dest = dest;
    r.flagEn = flagEn; r.clr = clr; r.out = out; r.c = c; r.s = s; r.z = z;
    r.stall = stall; r.flush = flush;
    return r;
  endfunction

  function automatic exp_t mkE(input logic valid, wen, input logic [RAW-1:0] addr,
                               input logic [DW-1:0] data, input logic c, s, z);
    exp_t r;
    r.valid = valid; r.wen = wen; r.addr = addr; r.data = data;
    r.c = c; r.s = s; r.z = z;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Bubble cycles carry no WB output, so they are checked directly.
  task automatic checkOutput(input exp_t e);
    cmp("bubble_wb_valid", 32'(WB_VALID), 32'(e.valid));
    cmp("bubble_wb_wen",   32'(WB_WEN),   32'(e.wen));
    cmp("bubble_c_flag",   32'(C_FLAG),   32'(e.c));
    cmp("bubble_s_flag",   32'(S_FLAG),   32'(e.s));
    cmp("bubble_z_flag",   32'(Z_FLAG),   32'(e.z));
  endtask

  task automatic checkFwd(input logic [RAW-1:0] srcA, srcB, input logic hitA, hitB);
    SRC_A_ADDR = srcA;
    SRC_B_ADDR = srcB;
    #1;
    cmp("fwd_a_hit", 32'(FWD_A_HIT), 32'(hitA));
    cmp("fwd_b_hit", 32'(FWD_B_HIT), 32'(hitB));
  endtask

  task automatic applyStimulus(input stim_t s, input exp_t e);
    RESET      = s.reset;
    EX_VALID   = s.valid;
    EX_OP      = s.op;
    EX_WEN     = s.wen;
    EX_DEST    = s.dest;
    EX_FLAG_EN = s.flagEn;
    CLR_FLAGS  = s.clr;
    ALU_OUT    = s.out;
    ALU_C_OUT  = s.c;
    ALU_S_OUT  = s.s;
    ALU_ZERO   = s.z;
    STALL      = s.stall;
    FLUSH      = s.flush;
    @(posedge CLK);
    if (e.valid) expQ.push_back(e);
    @(negedge CLK);
    if (!e.valid) checkOutput(e);
  endtask

  // Monitor: every cycle the DUT presents a live WB entry, pop and compare.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (WB_VALID === 1'b1) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL wb_unexpected: actual WB_VALID=1 required=no live entry");
        end else begin
          e = expQ.pop_front();
          cmp("wb_wen",  32'(WB_WEN),  32'(e.wen));
          cmp("wb_addr", 32'(WB_ADDR), 32'(e.addr));
          cmp("wb_data", 32'(WB_DATA), 32'(e.data));
          cmp("c_flag",  32'(C_FLAG),  32'(e.c));
          cmp("s_flag",  32'(S_FLAG),  32'(e.s));
          cmp("z_flag",  32'(Z_FLAG),  32'(e.z));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] simulation timed out");
  end

  task automatic checkAllZero(input string tag);
    cmp({tag, "_c"},     32'(C_FLAG),    0);
    cmp({tag, "_s"},     32'(S_FLAG),    0);
    cmp({tag, "_z"},     32'(Z_FLAG),    0);
    cmp({tag, "_valid"}, 32'(WB_VALID),  0);
    cmp({tag, "_wen"},   32'(WB_WEN),    0);
    cmp({tag, "_addr"},  32'(WB_ADDR),   0);
    cmp({tag, "_data"},  32'(WB_DATA),   0);
    cmp({tag, "_fwd_a"}, 32'(FWD_A_HIT), 0);
    cmp({tag, "_fwd_b"}, 32'(FWD_B_HIT), 0);
  endtask

  initial begin : stimulus
    RESET = 1'b1; EX_VALID = 1'b1; EX_OP = kPASS; EX_WEN = 1'b1; EX_DEST = '1;
    EX_FLAG_EN = 1'b1; CLR_FLAGS = 1'b1; ALU_OUT = '1; ALU_C_OUT = 1'b1;
    ALU_S_OUT = 1'b1; ALU_ZERO = 1'b1; STALL = 1'b1; FLUSH = 1'b1;
    SRC_A_ADDR = '1; SRC_B_ADDR = '1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checkAllZero("reset");
    SRC_A_ADDR = '0;
    SRC_B_ADDR = '0;

    // Two-byte add: clear, low byte FF+01 carries into r2, high byte absorbs carry into r3.
    applyStimulus(mkS(0,0,kADD,0,3'd0,0,1,8'h00,0,0,0,0,0), mkE(0,0,3'd0,8'h00,0,0,0));
    applyStimulus(mkS(0,1,kADD,1,3'd2,1,0,8'h00,1,0,1,0,0), mkE(1,1,3'd2,8'h00,1,0,1));
    applyStimulus(mkS(0,1,kADD,1,3'd3,1,0,8'h01,0,0,0,0,0), mkE(1,1,3'd3,8'h01,0,0,0));

    // Shift sets S only; XOR with flag enable touches only Z.
    applyStimulus(mkS(0,1,kSHR,1,3'd4,1,0,8'h40,1,1,0,0,0), mkE(1,1,3'd4,8'h40,0,1,0));
    applyStimulus(mkS(0,1,kXOR,1,3'd1,1,0,8'h00,1,0,1,0,0), mkE(1,1,3'd1,8'h00,0,1,1));
    applyStimulus(mkS(0,1,kOR, 1,3'd6,1,0,8'h5A,1,0,0,0,0), mkE(1,1,3'd6,8'h5A,0,1,0));

    // Three stalled cycles with a new instruction waiting: everything frozen.
    applyStimulus(mkS(0,1,kADD,1,3'd7,1,0,8'h11,1,0,1,1,0), mkE(1,1,3'd6,8'h5A,0,1,0));
    applyStimulus(mkS(0,1,kADD,1,3'd7,1,0,8'h11,1,0,1,1,0), mkE(1,1,3'd6,8'h5A,0,1,0));
    applyStimulus(mkS(0,1,kADD,1,3'd7,1,1,8'h11,1,0,1,1,0), mkE(1,1,3'd6,8'h5A,0,1,0));
    applyStimulus(mkS(0,1,kSUB,1,3'd7,1,1,8'h22,1,1,1,1,1), mkE(0,0,3'd0,8'h00,0,1,0));
    applyStimulus(mkS(0,0,kADD,0,3'd0,0,0,8'h00,0,0,0,0,0), mkE(0,0,3'd0,8'h00,0,1,0));

    // Forwarding: r5 live, r0 never forwarded, non-writing entry never forwarded.
    applyStimulus(mkS(0,1,kPASS,1,3'd5,0,0,8'h3C,1,0,1,0,0), mkE(1,1,3'd5,8'h3C,0,1,0));
    checkFwd(3'd5, 3'd4, 1'b1, 1'b0);
    checkFwd(3'd5, 3'd5, 1'b1, 1'b1);
    applyStimulus(mkS(0,1,kAND,1,3'd0,0,0,8'h3C,0,0,0,0,0), mkE(1,1,3'd0,8'h3C,0,1,0));
    checkFwd(3'd0, 3'd0, 1'b0, 1'b0);
    applyStimulus(mkS(0,1,kADD,0,3'd2,0,0,8'h99,1,1,1,0,0), mkE(1,0,3'd2,8'h99,0,1,0));
    checkFwd(3'd2, 3'd2, 1'b0, 1'b0);

    // Clear alongside a flag write: the op's own flag wins, the other clears.
    applyStimulus(mkS(0,1,kADD,1,3'd1,1,1,8'h80,1,1,0,0,0), mkE(1,1,3'd1,8'h80,1,0,0));
    applyStimulus(mkS(0,1,kSHL,1,3'd2,1,1,8'h00,1,1,1,0,0), mkE(1,1,3'd2,8'h00,0,1,1));
    applyStimulus(mkS(0,0,kADD,0,3'd0,0,1,8'h00,0,0,0,0,0), mkE(0,0,3'd0,8'h00,0,0,1));

    // FLUSH alone and flag-enable without a valid instruction leave flags alone.
    applyStimulus(mkS(0,1,kSUB,1,3'd4,1,1,8'h12,1,1,0,0,1), mkE(0,0,3'd0,8'h00,0,0,1));
    applyStimulus(mkS(0,0,kADD,1,3'd4,1,0,8'h12,1,1,0,0,0), mkE(0,0,3'd0,8'h00,0,0,1));

    // Reset mid-sequence wins over STALL.
    applyStimulus(mkS(0,1,kADD,1,3'd3,1,0,8'h77,1,0,0,0,0), mkE(1,1,3'd3,8'h77,1,0,0));
    checkFwd(3'd3, 3'd1, 1'b1, 1'b0);
    applyStimulus(mkS(1,1,kADD,1,3'd5,1,0,8'h55,1,1,1,1,0), mkE(0,0,3'd0,8'h00,0,0,0));
    checkAllZero("midreset");
    applyStimulus(mkS(0,0,kADD,0,3'd0,0,0,8'h00,0,0,0,0,0), mkE(0,0,3'd0,8'h00,0,0,0));

    repeat (2) @(negedge CLK);
    cmp("scoreboard_drained", 32'(expQ.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_writeback.md
# exec_writeback

Execute/writeback pipeline stage directly downstream of the 8-bit ALU. It registers the ALU result and destination for the register-file write port. It owns the architectural carry (C), shift-out (S) and zero (Z) flags, and feeds C and S back to the ALU as its `C_IN`/`S_IN` for multi-byte add/subtract and chained shifts. It also provides one-level result forwarding to the operand muxes of the next instruction.

## Interface
- `DW`, 8: datapath width; must match the ALU.
- `RAW`, 3: register-file address width.
- Clocking: one clock, `CLK`. Reset is `RESET`, synchronous and active-high.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `EX_VALID`  in  1  the ALU is presenting a real instruction this cycle.
- `EX_OP`  in  3  ALU opcode of that instruction (`op_mne`).
- `EX_WEN`  in  1  the instruction writes a register.
- `EX_DEST`  in  RAW  destination register.
- `EX_FLAG_EN`  in  1  the instruction updates flags.
- `CLR_FLAGS`  in  1  clears C and S (start of a multi-byte sequence).
- `ALU_OUT`  in  DW  ALU result.
- `ALU_C_OUT`, `ALU_S_OUT`, `ALU_ZERO`  in  1 each  ALU flag outputs.
- `STALL`  in  1  hold stage contents.
- `FLUSH`  in  1  kill the incoming instruction.
- `SRC_A_ADDR`, `SRC_B_ADDR`  in  RAW  source registers of the instruction being decoded.
- `C_FLAG`  out  1  carry flag; drives ALU `C_IN`.
- `S_FLAG`  out  1  shift flag; drives ALU `S_IN`.
- `Z_FLAG`  out  1  zero flag; consumed by branch logic.
- `WB_VALID`  out  1  the WB register holds a live instruction.
- `WB_WEN`  out  1  register-file write enable; equals `WB_VALID & wen_q`.
- `WB_ADDR`  out  RAW  write address.
- `WB_DATA`  out  DW  write data; also the forwarding data.
- `FWD_A_HIT`, `FWD_B_HIT`  out  1 each  the corresponding source should take `WB_DATA`.

## Operation
- **Priority, per cycle:** `RESET` > `FLUSH` > `STALL` > accept.
- **Accept** (`EX_VALID & ~STALL & ~FLUSH`):
  - The WB register loads `ALU_OUT`, `EX_DEST` and `EX_WEN`.
  - `WB_VALID` becomes 1.
- **Bubble** (`~EX_VALID & ~STALL`, or `FLUSH`):
  - `WB_VALID` and `wen_q` become 0.
  - Data and address hold their old values (don't-care).
- **STALL without FLUSH:**
  - All WB registers and flags hold.
  - A held write repeats; this is idempotent and legal.
- **Flag update** only on accept with `EX_FLAG_EN` = 1:
  - `kADD`, `kSUB`: C ← `ALU_C_OUT`.
  - `kSHL`, `kSHR`: S ← `ALU_S_OUT`.
  - Z ← `ALU_ZERO` for every op.
  - Any flag not named for the op holds.
- **`CLR_FLAGS`:**
  - Clears C and S when not stalled and not flushed. Z is unaffected.
  - If asserted in the same cycle as a flag-updating accept, the op's own flag write wins; the other of C/S clears.
- **Forwarding:**
  - `FWD_x_HIT = WB_WEN & (SRC_x_ADDR == WB_ADDR) & (WB_ADDR != 0)`.
  - Register 0 is hardwired zero and is never forwarded.
  - This path is combinational from the WB registers and the `SRC` inputs.
- **FLUSH** never alters flags. An in-flight instruction already in the WB register is not recalled.
- **Reset values:**
  - `C_FLAG` = `S_FLAG` = `Z_FLAG` = 0.
  - `WB_VALID` = `WB_WEN` = 0.
  - `WB_ADDR` = 0, `WB_DATA` = 0.
  - `FWD_A_HIT` = `FWD_B_HIT` = 0.

## Timing
- EX→WB latency is one cycle: an instruction accepted at edge *n* drives `WB_*` during cycle *n+1*.
- Flags written at edge *n* are visible on `C_FLAG`/`S_FLAG` in cycle *n+1*. Back-to-back multi-byte ops therefore chain with no bubble.
- All outputs except `FWD_*_HIT` come directly from flops.
- `RESET` asserted mid-sequence clears everything at the next edge, regardless of `STALL`/`FLUSH`.

## Structure
- Shared package `definitions`:
  - Keeps the `op_mne` enum (`kADD`, `kSUB`, `kSHL`, `kSHR`, `kXOR`, `kAND`, `kOR`, `kPASS`).
  - Adds a `flags_t` packed struct `{c, s, z}`.
  - Adds the constant `kZERO_REG` = 0.
- One sub-module, `flag_reg`:
  - Holds C/S/Z.
  - Implements the op-to-flag selection and the `CLR_FLAGS` merge.
  - Has its own `CLK`/`RESET`.
- The top level instantiates `flag_reg`, the WB pipeline register and the forwarding comparators.

## Test plan
- **Reset:** hold `RESET` for 2 cycles with all inputs at 1 → all outputs 0 the cycle after release.
- **16-bit add chain:**
  - Stimulus: `CLR_FLAGS`, then `kADD` 0xFF+0x01 (ALU `C_OUT`=1, `OUT`=0x00, `ZERO`=1) into r2, then the next `kADD` into r3.
  - Required: `C_FLAG`=1 and `Z_FLAG`=1 in the following cycle; `WB_ADDR`=2, `WB_DATA`=0x00.
- **Shift chain:**
  - Stimulus: `kSHR` by 1 with `ALU_S_OUT`=1, `EX_FLAG_EN`=1.
  - Required: `S_FLAG`=1 next cycle and C unchanged. A subsequent `kXOR` with flag enable updates only Z.
- **Stall/flush:**
  - `STALL` for 3 cycles with a new `EX_VALID` → `WB_*` and flags frozen.
  - `STALL`+`FLUSH` together → `WB_VALID`=0 next cycle and flags unchanged.
- **Forwarding:**
  - WB holds r5=0x3C with `WB_WEN`=1 and `SRC_A_ADDR`=5 → `FWD_A_HIT`=1.
  - `SRC_B_ADDR`=4 → `FWD_B_HIT`=0.
  - A write to r0 → both hits 0.
- **Simultaneous clear and update:** `CLR_FLAGS` with `kADD` (`ALU_C_OUT`=1), S previously 1 → next cycle C=1, S=0.
